// File: rtl/lfsr_checker_if.sv
// Receive-side bus for the LFSR checker: word stream in, lock/error status out.
interface lfsr_checker_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    modport master (
        output in_valid,
        output in_data,
        output clr_err,
        input  locked,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  clr_err,
        output locked,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// LFSR stream checker: hunts for a seed, confirms LOCK_CNT predicted words,
// then flywheels the sequence and counts mismatches until LOSS_CNT in a row.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_checker_if.slave bus
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned EW = 16;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   expected, expected_nxt;
    logic [CW-1:0]   match_cnt, match_cnt_nxt;
    logic [CW-1:0]   miss_cnt, miss_cnt_nxt;
    logic            locked_nxt;
    logic            err_pulse_nxt;
    logic [EW-1:0]   err_count_nxt;
    logic [CW-1:0]   match_inc;
    logic [CW-1:0]   miss_inc;
    logic            word_ok;

    // One-to-many Galois step for x^8+x^4+x^3+x^2+1.
    function automatic logic [DW-1:0] next_word(input logic [DW-1:0] s);
        return {s[6], s[5], s[4], s[3] ^ s[7], s[2] ^ s[7], s[1] ^ s[7], s[0], s[7]};
    endfunction

    assign match_inc = match_cnt + CW'(1);
    assign miss_inc  = miss_cnt + CW'(1);
    assign word_ok   = (bus.in_data == expected);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            expected      <= '0;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            bus.locked    <= 1'b0;
            bus.err_pulse <= 1'b0;
            bus.err_count <= '0;
        end else begin
            state         <= state_nxt;
            expected      <= expected_nxt;
            match_cnt     <= match_cnt_nxt;
            miss_cnt      <= miss_cnt_nxt;
            bus.locked    <= locked_nxt;
            bus.err_pulse <= err_pulse_nxt;
            bus.err_count <= err_count_nxt;
        end
    end

    // Next-state: seed in HUNT/SYNC, flywheel prediction once locked.
    always_comb begin
        state_nxt     = state;
        expected_nxt  = expected;
        match_cnt_nxt = match_cnt;
        miss_cnt_nxt  = miss_cnt;
        err_pulse_nxt = 1'b0;
        err_count_nxt = bus.err_count;

        if (bus.in_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.in_data != '0) begin
                        expected_nxt  = next_word(bus.in_data);
                        match_cnt_nxt = '0;
                        state_nxt     = SYNC;
                    end
                end
                SYNC: begin
                    if (word_ok) begin
                        expected_nxt  = next_word(bus.in_data);
                        match_cnt_nxt = match_inc;
                        if (match_inc == CW'(LOCK_CNT)) begin
                            state_nxt    = LOCK;
                            miss_cnt_nxt = '0;
                        end
                    end else if (bus.in_data != '0) begin
                        expected_nxt  = next_word(bus.in_data);
                        match_cnt_nxt = '0;
                    end else begin
                        state_nxt = HUNT;
                    end
                end
                LOCK: begin
                    expected_nxt = next_word(expected);
                    if (word_ok) begin
                        miss_cnt_nxt = '0;
                    end else begin
                        miss_cnt_nxt  = miss_inc;
                        err_pulse_nxt = 1'b1;
                        if (bus.err_count != {EW{1'b1}}) begin
                            err_count_nxt = bus.err_count + EW'(1);
                        end
                        if (miss_inc == CW'(LOSS_CNT)) begin
                            state_nxt = HUNT;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end

        if (bus.clr_err) begin
            err_count_nxt = '0;
        end

        locked_nxt = (state_nxt == LOCK);
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed streams on two instances, checked each
// cycle against a word-level model plus hand-computed literal expectations.
module tb_lfsr_checker;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    bit   armed = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lfsr_checker_if a ();
    lfsr_checker_if b ();

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3))  dut_a (.clk(clk), .rst(rst_a), .bus(a));
    lfsr_checker #(.LOCK_CNT(1), .LOSS_CNT(15)) dut_b (.clk(clk), .rst(rst_b), .bus(b));

    // Multiply by x modulo the generator polynomial 0x11D.
    function automatic logic [7:0] nx(input logic [7:0] s);
        logic [8:0] v;
        v = {s, 1'b0};
        if (v[8]) v = v ^ 9'h11D;
        return v[7:0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: mode 0=hunting, 1=confirming, 2=locked.
    int         m_mode   [2];
    logic [7:0] m_pred   [2];
    int         m_run    [2];
    int         m_miss   [2];
    int         m_errs   [2];
    int         m_locked [2];
    int         m_pulse  [2];
    int         lock_need[2] = '{4, 1};
    int         loss_need[2] = '{3, 15};

    task automatic model_step(input int k, input logic r, input logic v,
                              input logic [7:0] d, input logic c);
        if (r) begin
            m_mode[k] = 0; m_pred[k] = 8'h00; m_run[k] = 0; m_miss[k] = 0;
            m_errs[k] = 0; m_locked[k] = 0; m_pulse[k] = 0;
            return;
        end
        m_pulse[k] = 0;
        if (v) begin
            if (m_mode[k] == 2) begin
                if (d == m_pred[k]) begin
                    m_miss[k] = 0;
                end else begin
                    m_miss[k]++;
                    m_pulse[k] = 1;
                    if (m_errs[k] < 65535) m_errs[k]++;
                    if (m_miss[k] == loss_need[k]) m_mode[k] = 0;
                end
                m_pred[k] = nx(m_pred[k]);
            end else if (m_mode[k] == 1 && d == m_pred[k]) begin
                m_pred[k] = nx(d);
                m_run[k]++;
                if (m_run[k] == lock_need[k]) begin
                    m_mode[k] = 2;
                    m_miss[k] = 0;
                end
            end else if (d != 8'h00) begin
                m_pred[k] = nx(d);
                m_run[k] = 0;
                m_mode[k] = 1;
            end else begin
                m_mode[k] = 0;
            end
        end
        if (c) m_errs[k] = 0;
        m_locked[k] = (m_mode[k] == 2) ? 1 : 0;
    endtask

    // Advance the model on every edge and compare both instances just after.
    always @(posedge clk) begin
        model_step(0, rst_a, a.in_valid, a.in_data, a.clr_err);
        model_step(1, rst_b, b.in_valid, b.in_data, b.clr_err);
        #1;
        if (armed) begin
            check("a_locked",    int'(a.locked),    m_locked[0]);
            check("a_err_pulse", int'(a.err_pulse), m_pulse[0]);
            check("a_err_count", int'(a.err_count), m_errs[0]);
            check("b_locked",    int'(b.locked),    m_locked[1]);
            check("b_err_pulse", int'(b.err_pulse), m_pulse[1]);
            check("b_err_count", int'(b.err_count), m_errs[1]);
        end
    end

    task automatic step_a(input logic r, input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        rst_a = r; a.in_valid = v; a.in_data = d; a.clr_err = c;
        b.in_valid = 1'b0; b.clr_err = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic step_b(input logic r, input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        rst_b = r; b.in_valid = v; b.in_data = d; b.clr_err = c;
        a.in_valid = 1'b0; a.clr_err = 1'b0;
        @(posedge clk);
        #2;
    endtask

    logic [7:0] cur;
    logic [7:0] seq1 [5] = '{8'hBD, 8'h67, 8'hCE, 8'h81, 8'h1F};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a.in_valid = 1'b0; a.in_data = 8'h00; a.clr_err = 1'b0;
        b.in_valid = 1'b0; b.in_data = 8'h00; b.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        armed = 1'b1;
        check("rst_locked", int'(a.locked), 0);
        check("rst_pulse",  int'(a.err_pulse), 0);
        check("rst_count",  int'(a.err_count), 0);

        // Acquire lock on BD,67,CE,81,1F.
        for (int i = 0; i < 5; i++) begin
            step_a(1'b0, 1'b1, seq1[i], 1'b0);
            if (i == 3) check("lock_not_yet", int'(a.locked), 0);
        end
        check("lock_after_1f", int'(a.locked), 1);
        check("lock_count0",   int'(a.err_count), 0);
        check("model_pin_lock", m_locked[0], 1);
        check("nx_1f_pin", int'(nx(8'h1F)), 'h3E);

        // Single dropout: 0x3E replaced by 0x00, then 0x7C follows.
        step_a(1'b0, 1'b1, 8'h00, 1'b0);
        check("drop_pulse",  int'(a.err_pulse), 1);
        check("drop_count",  int'(a.err_count), 1);
        check("drop_locked", int'(a.locked), 1);
        check("model_pin_errs", m_errs[0], 1);
        step_a(1'b0, 1'b1, 8'h7C, 1'b0);
        check("resume_pulse", int'(a.err_pulse), 0);
        check("resume_count", int'(a.err_count), 1);
        cur = nx(8'h7C);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 1'b1, cur, 1'b0);
            cur = nx(cur);
        end

        // Clear, then three corrupted words lose lock; a fourth is not counted.
        step_a(1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_count", int'(a.err_count), 0);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 1'b1, cur ^ 8'h5A, 1'b0);
            cur = nx(cur);
        end
        check("loss_count",  int'(a.err_count), 3);
        check("loss_locked", int'(a.locked), 0);
        check("loss_pulse",  int'(a.err_pulse), 1);
        step_a(1'b0, 1'b1, cur ^ 8'h5A, 1'b0);
        check("hunt_no_inc",   int'(a.err_count), 3);
        check("hunt_no_pulse", int'(a.err_pulse), 0);

        // Zeros keep HUNT; gapped stream still locks after four matches.
        step_a(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1, 8'h00, 1'b0);
        check("zero_locked", int'(a.locked), 0);
        check("zero_count",  int'(a.err_count), 0);
        for (int i = 0; i < 5; i++) begin
            step_a(1'b0, 1'b1, seq1[i], 1'b0);
            if (i < 4) step_a(1'b0, 1'b0, 8'hFF, 1'b0);
            if (i == 3) check("gap_not_yet", int'(a.locked), 0);
        end
        check("gap_locked", int'(a.locked), 1);

        // SYNC mismatch reseeds silently.
        step_a(1'b1, 1'b0, 8'h00, 1'b0);
        step_a(1'b0, 1'b1, 8'hBD, 1'b0);
        step_a(1'b0, 1'b1, 8'h55, 1'b0);
        check("sync_mis_pulse", int'(a.err_pulse), 0);
        cur = nx(8'h55);
        for (int i = 0; i < 4; i++) begin
            step_a(1'b0, 1'b1, cur, 1'b0);
            cur = nx(cur);
        end
        check("reseed_locked", int'(a.locked), 1);
        check("reseed_count",  int'(a.err_count), 0);

        // One error while locked, then reset mid-stream clears everything.
        step_a(1'b0, 1'b1, cur ^ 8'h01, 1'b0);
        cur = nx(cur);
        check("pre_rst_count", int'(a.err_count), 1);
        step_a(1'b1, 1'b1, cur, 1'b0);
        check("rst_mid_locked", int'(a.locked), 0);
        check("rst_mid_pulse",  int'(a.err_pulse), 0);
        check("rst_mid_count",  int'(a.err_count), 0);
        cur = 8'h3E;
        for (int i = 0; i < 5; i++) begin
            step_a(1'b0, 1'b1, cur, 1'b0);
            cur = nx(cur);
        end
        check("post_rst_locked", int'(a.locked), 1);
        step_a(1'b0, 1'b0, 8'h00, 1'b0);

        // Saturation on the long-tolerance instance: 14 misses then a match.
        step_b(1'b0, 1'b1, 8'h01, 1'b0);
        step_b(1'b0, 1'b1, 8'h02, 1'b0);
        check("b_locked_pin", int'(b.locked), 1);
        cur = 8'h04;
        for (int j = 0; j < 4681; j++) begin
            for (int i = 0; i < 14; i++) begin
                step_b(1'b0, 1'b1, cur ^ 8'hA5, 1'b0);
                cur = nx(cur);
            end
            step_b(1'b0, 1'b1, cur, 1'b0);
            cur = nx(cur);
        end
        check("b_count_65534", int'(b.err_count), 65534);
        step_b(1'b0, 1'b1, cur ^ 8'hA5, 1'b0);
        cur = nx(cur);
        check("sat_count", int'(b.err_count), 'hFFFF);
        step_b(1'b0, 1'b1, cur ^ 8'hA5, 1'b0);
        cur = nx(cur);
        check("sat_hold",  int'(b.err_count), 'hFFFF);
        check("sat_pulse", int'(b.err_pulse), 1);
        step_b(1'b0, 1'b1, cur ^ 8'hA5, 1'b1);
        check("clr_prio_count", int'(b.err_count), 0);
        check("clr_prio_pulse", int'(b.err_pulse), 1);
        step_b(1'b0, 1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
